arrow_lane_scheduler: RTL
=========================

Name: arrow_lane_scheduler

Overview:
- Sequences the two-player arrow display datapath.
- Owns the two 26-slot arrow arrays (3 bits per slot, slot 0 at the top of the screen) and the two 2-bit hit indicators that the background/arrow index identifier renders.
- Advances the arrays once every FRAMES_PER_STEP frame ticks and fetches new steps from the chart ROM over a req/valid handshake.
- Grades player presses against the hit zone and keeps per-player scores.

Parameters:
- FRAMES_PER_STEP, 4, frame ticks per one-slot scroll (1..15).
- HOLD_FRAMES, 30, frame ticks an indicator grade stays visible before returning to 2'b00.
- SCORE_W, 16, score counter width.

Ports:
- clock  in  1  system clock (single domain).
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  pulse; begins a song from IDLE or DONE.
- pause  in  1  level; freezes scrolling while high.
- step_req  out  1  request the next chart step.
- step_valid  in  1  ROM response strobe for step_data/step_last.
- step_data  in  3  arrow code: 0 none, 1 up, 2 left, 3 down, 4 right, 5 shake.
- step_last  in  1  marks the final chart step.
- p1_press, p2_press  in  3  one-cycle press codes (0 = no press).
- p1_arrow_array, p2_arrow_array  out  78  slot k at bits [3k+2:3k].
- p1_indicator, p2_indicator  out  2  11 excellent, 10 good, 01 bad, 00 none.
- p1_score, p2_score  out  SCORE_W  running scores.
- busy  out  1  high in PLAY, PAUSE, DRAIN.

Behaviour:
- Reset (synchronous): state IDLE, arrays 0, indicators 00, scores 0, step_req 0, hold and frame counters 0, staged step empty.
- FSM states: IDLE, PLAY, PAUSE, DRAIN, DONE.
  - IDLE/DONE + start -> PLAY. Entering PLAY clears arrays and scores, zeroes the frame counter, and raises step_req.
  - PLAY + pause -> PAUSE; PAUSE + !pause -> PLAY. In PAUSE, ticks are ignored, arrays are frozen, and presses are ignored.
  - PLAY -> DRAIN when the accepted step has step_last=1, on the advance that inserts it.
  - DRAIN -> DONE once both arrays are all-zero.
  - start in PLAY, PAUSE or DRAIN is ignored.
- Step handshake:
  - step_req stays high until the cycle step_valid is seen. The step is captured into a one-entry stage and step_req drops.
  - step_req re-asserts the cycle after the stage is consumed by an advance.
  - step_valid while step_req=0 is ignored.
  - Stage empty at advance time: insert code 0 and keep step_req high (no stall).
- Advance timing:
  - In PLAY, each frame_tick increments the frame counter.
  - When the count reaches FRAMES_PER_STEP-1, the next tick advances and resets the counter.
- Advance action:
  - slot k -> k+1 in both arrays.
  - Slot 0 <- staged code in PLAY, 0 in DRAIN.
  - The old slot 25 drops out.
- Hit zone and grading (press code c != 0), per player and independent:
  - Search order is slot 23, then 22, then 24.
  - First slot equal to c: 23 -> excellent, +2 score; 22 or 24 -> good, +1 score. The matched slot is cleared to 0.
  - No match -> bad; score unchanged.
  - Codes 6 and 7 always grade bad.
- Miss: a nonzero code leaving slot 25 on an advance grades bad.
- Indicator update:
  - A grade event loads the indicator and sets the hold counter to HOLD_FRAMES.
  - Each frame_tick decrements a nonzero hold counter. At 0 the indicator returns to 00.
  - The hold counter also runs in DRAIN and DONE.
- Simultaneous events in one cycle:
  - Grading uses pre-advance slot contents. The clear is applied first, then the shift; the cleared slot shifts as 0.
  - Press grade and miss in the same cycle: the press grade wins the indicator. The score still reflects the press.
- Score saturates at all-ones.
- Latency: array, indicator and score changes appear on the cycle after the causing tick or press.
- Reset mid-song returns everything to the reset values; any step_valid in flight is dropped.

Decomposition:
- Shared package arrow_pkg holds:
  - arrow code constants;
  - indicator encodings (EXCELLENT=2'b11, GOOD=2'b10, BAD=2'b01, NONE=2'b00);
  - NUM_SLOTS=26, HIT_CENTER=23.
- One sub-module, player_lane_grader, instantiated twice. Each instance holds its player's array, grading, hold counter and score. A shared advance strobe and the insert code are driven by the top FSM.

Test Plan:
- Reset then start, ROM answers 2 cycles after step_req with data=1,2,3 -> after 3 advances (12 ticks at FRAMES_PER_STEP=4), slot0=3, slot1=2, slot2=1 in both arrays.
- Place code 4 in p1 slot 23, pulse p1_press=4 -> p1_indicator=11, p1_score=2, slot 23 becomes 0; p2 unaffected.
- Slot 22 holds 1 and slot 24 holds 1, press 1 -> slot 22 cleared, indicator 10, score +1. A press of 2 with no match -> indicator 01, score unchanged.
- Code 5 in slot 25 unpressed, advance -> indicator 01. The same cycle also carries an excellent press -> indicator 11.
- step_last on the 3rd step -> DRAIN, busy=1. DONE reached 26 advances after the last insert. Indicator clears after HOLD_FRAMES ticks.
- Assert pause for 10 ticks mid-song -> arrays frozen, presses ignored; assert reset mid-PLAY -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/arrow_lane_scheduler_pkg.sv
// Shared types and constants for the arrow lane scheduler.
// Arrow codes, indicator grades, slot geometry, FSM states.
package arrow_pkg;

  localparam int NUM_SLOTS  = 26;
  localparam int HIT_CENTER = 23;
  localparam int ARRAY_W    = 3 * NUM_SLOTS;

  localparam logic [2:0] ARROW_NONE  = 3'd0;
  localparam logic [2:0] ARROW_UP    = 3'd1;
  localparam logic [2:0] ARROW_LEFT  = 3'd2;
  localparam logic [2:0] ARROW_DOWN  = 3'd3;
  localparam logic [2:0] ARROW_RIGHT = 3'd4;
  localparam logic [2:0] ARROW_SHAKE = 3'd5;

  localparam logic [1:0] IND_EXCELLENT = 2'b11;
  localparam logic [1:0] IND_GOOD      = 2'b10;
  localparam logic [1:0] IND_BAD       = 2'b01;
  localparam logic [1:0] IND_NONE      = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE,
    S_DRAIN,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/arrow_lane_scheduler_if.sv
// Chart ROM step handshake bundle.
// master = scheduler (requester), slave = ROM.
interface arrow_step_if;
  logic       step_req;
  logic       step_valid;
  logic [2:0] step_data;
  logic       step_last;

  modport master (
    output step_req,
    input  step_valid,
    input  step_data,
    input  step_last
  );

  modport slave (
    input  step_req,
    output step_valid,
    output step_data,
    output step_last
  );
endinterface

// File: rtl/arrow_lane_scheduler_grader.sv
// One player's lane: arrow array, press grading,
// indicator hold timer and saturating score.
module player_lane_grader
  import arrow_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int SCORE_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  input  logic [2:0]         insert_code,
  input  logic               grade_en,
  input  logic               hold_en,
  input  logic               frame_tick,
  input  logic [2:0]         press,
  output logic [ARRAY_W-1:0] arrow_array,
  output logic [1:0]         indicator,
  output logic [SCORE_W-1:0] score,
  output logic               all_zero
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int TOP    = 3 * (NUM_SLOTS - 1);
  localparam int LO     = 3 * (HIT_CENTER - 1);
  localparam int MID    = 3 * HIT_CENTER;
  localparam int HI     = 3 * (HIT_CENTER + 1);

  logic [ARRAY_W-1:0] arr_q, arr_d, arr_clr;
  logic [1:0]         ind_q, ind_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum;
  logic [1:0]         inc;
  logic               press_v, miss;
  logic               hit_c, hit_lo, hit_hi;

  // hit-zone search: centre first, then above, then below
  always_comb begin
    hit_c   = 1'b0;
    hit_lo  = 1'b0;
    hit_hi  = 1'b0;
    press_v = grade_en && (press != ARROW_NONE);
    if (press_v && press <= ARROW_SHAKE) begin
      if (arr_q[MID +: 3] == press)
        hit_c = 1'b1;
      else if (arr_q[LO +: 3] == press)
        hit_lo = 1'b1;
      else if (arr_q[HI +: 3] == press)
        hit_hi = 1'b1;
    end
    miss = advance && (arr_q[TOP +: 3] != ARROW_NONE);
  end

  // clear the matched slot, then shift with the insert code
  always_comb begin
    arr_clr = arr_q;
    if (hit_c)  arr_clr[MID +: 3] = ARROW_NONE;
    if (hit_lo) arr_clr[LO +: 3]  = ARROW_NONE;
    if (hit_hi) arr_clr[HI +: 3]  = ARROW_NONE;
    if (clear)
      arr_d = '0;
    else if (advance)
      arr_d = {arr_clr[ARRAY_W-4:0], insert_code};
    else
      arr_d = arr_clr;
  end

  // saturating score, cleared at song start
  always_comb begin
    inc = hit_c ? 2'd2 : ((hit_lo || hit_hi) ? 2'd1 : 2'd0);
    sum = {1'b0, score_q} + (SCORE_W+1)'(inc);
    if (clear)
      score_d = '0;
    else if (sum[SCORE_W])
      score_d = '1;
    else
      score_d = sum[SCORE_W-1:0];
  end

  // press grade beats miss; otherwise the hold timer runs down
  always_comb begin
    ind_d  = ind_q;
    hold_d = hold_q;
    if (press_v) begin
      if (hit_c)
        ind_d = IND_EXCELLENT;
      else if (hit_lo || hit_hi)
        ind_d = IND_GOOD;
      else
        ind_d = IND_BAD;
      hold_d = HOLD_W'(HOLD_FRAMES);
    end else if (miss) begin
      ind_d  = IND_BAD;
      hold_d = HOLD_W'(HOLD_FRAMES);
    end else if (hold_en && frame_tick && hold_q != '0) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HOLD_W'(1))
        ind_d = IND_NONE;
    end
  end

  // lane state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      arr_q   <= '0;
      ind_q   <= IND_NONE;
      hold_q  <= '0;
      score_q <= '0;
    end else begin
      arr_q   <= arr_d;
      ind_q   <= ind_d;
      hold_q  <= hold_d;
      score_q <= score_d;
    end
  end

  assign arrow_array = arr_q;
  assign indicator   = ind_q;
  assign score       = score_q;
  assign all_zero    = (arr_q == '0);

endmodule

// File: rtl/arrow_lane_scheduler.sv
// Song sequencer: frame pacing, chart fetch stage,
// and the two player lanes.
module arrow_lane_scheduler
  import arrow_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES     = 30,
  parameter int SCORE_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  arrow_step_if.master       step,
  input  logic [2:0]         p1_press,
  input  logic [2:0]         p2_press,
  output logic [ARRAY_W-1:0] p1_arrow_array,
  output logic [ARRAY_W-1:0] p2_arrow_array,
  output logic [1:0]         p1_indicator,
  output logic [1:0]         p2_indicator,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               busy
);

  sched_state_e state_q, state_d;
  logic [3:0]   fcnt_q, fcnt_d;
  logic         req_q, req_d;
  logic         stg_v_q, stg_v_d;
  logic [2:0]   stg_c_q, stg_c_d;
  logic         stg_l_q, stg_l_d;
  logic         clear, adv, run;
  logic         grade_en, hold_en;
  logic [2:0]   ins;
  logic         p1_zero, p2_zero;

  // frame pacing, fetch stage and song state
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    req_d   = req_q;
    stg_v_d = stg_v_q;
    stg_c_d = stg_c_q;
    stg_l_d = stg_l_q;
    clear   = 1'b0;
    adv     = 1'b0;
    run     = (state_q == S_PLAY) || (state_q == S_DRAIN);
    if (run && frame_tick) begin
      if (fcnt_q == 4'(FRAMES_PER_STEP - 1)) begin
        adv    = 1'b1;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
    ins = (state_q == S_PLAY && stg_v_q) ? stg_c_q : ARROW_NONE;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PLAY;
          clear   = 1'b1;
          fcnt_d  = '0;
          req_d   = 1'b1;
          stg_v_d = 1'b0;
        end
      end
      S_PLAY: begin
        if (adv && stg_v_q) begin
          stg_v_d = 1'b0;
          if (!stg_l_q)
            req_d = 1'b1;
        end
        if (adv && stg_v_q && stg_l_q)
          state_d = S_DRAIN;
        else if (pause)
          state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (!pause)
          state_d = S_PLAY;
      end
      S_DRAIN: begin
        if (p1_zero && p2_zero)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (req_q && step.step_valid) begin
      stg_v_d = 1'b1;
      stg_c_d = step.step_data;
      stg_l_d = step.step_last;
      req_d   = 1'b0;
    end
  end

  // sequencer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      req_q   <= 1'b0;
      stg_v_q <= 1'b0;
      stg_c_q <= ARROW_NONE;
      stg_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      req_q   <= req_d;
      stg_v_q <= stg_v_d;
      stg_c_q <= stg_c_d;
      stg_l_q <= stg_l_d;
    end
  end

  assign grade_en = (state_q == S_PLAY) ||
                    (state_q == S_DRAIN);
  assign hold_en  = (state_q != S_PAUSE);

  player_lane_grader #(
    .HOLD_FRAMES (HOLD_FRAMES),
    .SCORE_W     (SCORE_W)
  ) u_p1 (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .advance     (adv),
    .insert_code (ins),
    .grade_en    (grade_en),
    .hold_en     (hold_en),
    .frame_tick  (frame_tick),
    .press       (p1_press),
    .arrow_array (p1_arrow_array),
    .indicator   (p1_indicator),
    .score       (p1_score),
    .all_zero    (p1_zero)
  );

  player_lane_grader #(
    .HOLD_FRAMES (HOLD_FRAMES),
    .SCORE_W     (SCORE_W)
  ) u_p2 (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .advance     (adv),
    .insert_code (ins),
    .grade_en    (grade_en),
    .hold_en     (hold_en),
    .frame_tick  (frame_tick),
    .press       (p2_press),
    .arrow_array (p2_arrow_array),
    .indicator   (p2_indicator),
    .score       (p2_score),
    .all_zero    (p2_zero)
  );

  assign step.step_req = req_q;
  assign busy = (state_q == S_PLAY)  ||
                (state_q == S_PAUSE) ||
                (state_q == S_DRAIN);

endmodule
